// File: rtl/rescue_detect.sv
// Rescue detector: tracks player/soldier sprite overlap over frames, then
// hands a banner box to the saved-drawing stage and retires the soldier.
module rescue_detect #(
  parameter int unsigned SPRITE_W       = 10,
  parameter int unsigned SPRITE_H       = 10,
  parameter int unsigned HIT_FRAMES     = 2,
  parameter int unsigned TIMEOUT_FRAMES = 40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [8:0] player_x,
  input  logic [7:0] player_y,
  input  logic [8:0] soldier_x,
  input  logic [7:0] soldier_y,
  input  logic       soldier_valid,
  input  logic       saved_done,
  output logic       start,
  output logic [8:0] x_position_a,
  output logic [7:0] y_position_a,
  output logic [8:0] x_position_b,
  output logic [7:0] y_position_b,
  output logic       soldier_clear,
  output logic [7:0] rescue_count,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned X_MAX = 319;
  localparam int unsigned Y_MAX = 239;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRACK = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  logic [2:0] state, state_nxt;
  logic [3:0] hit_cnt, hit_cnt_nxt;
  logic [5:0] frm_cnt, frm_cnt_nxt;
  logic       load_box, timeout_hit;

  logic [8:0] dx, min_x, max_x, box_xb;
  logic [7:0] dy, min_y, max_y, box_yb;
  logic [9:0] sum_x;
  logic [8:0] sum_y;
  logic       overlap;

  // Absolute differences taken by ordering operands, so nothing wraps.
  always_comb begin
    dx      = (player_x >= soldier_x) ? player_x - soldier_x : soldier_x - player_x;
    dy      = (player_y >= soldier_y) ? player_y - soldier_y : soldier_y - player_y;
    overlap = (dx < 9'(SPRITE_W)) && (dy < 8'(SPRITE_H));
    min_x   = (player_x < soldier_x) ? player_x : soldier_x;
    max_x   = (player_x < soldier_x) ? soldier_x : player_x;
    min_y   = (player_y < soldier_y) ? player_y : soldier_y;
    max_y   = (player_y < soldier_y) ? soldier_y : player_y;
    sum_x   = 10'(max_x) + 10'(SPRITE_W - 1);
    sum_y   = 9'(max_y) + 9'(SPRITE_H - 1);
    box_xb  = (sum_x > 10'(X_MAX)) ? 9'(X_MAX) : sum_x[8:0];
    box_yb  = (sum_y > 9'(Y_MAX)) ? 8'(Y_MAX) : sum_y[7:0];
  end

  // Next-state logic; a tick on the TRACK->ARM cycle is deliberately dropped.
  always_comb begin
    state_nxt   = state;
    hit_cnt_nxt = hit_cnt;
    frm_cnt_nxt = frm_cnt;
    load_box    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        hit_cnt_nxt = 4'd0;
        if (enable && soldier_valid) state_nxt = S_TRACK;
      end
      S_TRACK: begin
        if (!(enable && soldier_valid)) begin
          state_nxt   = S_IDLE;
          hit_cnt_nxt = 4'd0;
        end else if (hit_cnt == 4'(HIT_FRAMES)) begin
          state_nxt   = S_ARM;
          hit_cnt_nxt = 4'd0;
          load_box    = 1'b1;
        end else if (frame_tick) begin
          hit_cnt_nxt = overlap ? hit_cnt + 4'd1 : 4'd0;
        end
      end
      S_ARM: begin
        frm_cnt_nxt = 6'd0;
        if (frame_tick) state_nxt = S_SHOW;
      end
      S_SHOW: begin
        // Done is only trusted once a frame has elapsed in SHOW.
        if (saved_done && (frm_cnt != 6'd0)) begin
          state_nxt = S_CLEAR;
        end else if (frame_tick) begin
          if (frm_cnt == 6'(TIMEOUT_FRAMES - 1)) begin
            state_nxt   = S_CLEAR;
            timeout_hit = 1'b1;
          end else begin
            frm_cnt_nxt = frm_cnt + 6'd1;
          end
        end
      end
      S_CLEAR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      hit_cnt       <= 4'd0;
      frm_cnt       <= 6'd0;
      start         <= 1'b0;
      soldier_clear <= 1'b0;
      rescue_count  <= 8'd0;
      timeout_err   <= 1'b0;
      x_position_a  <= 9'd0;
      y_position_a  <= 8'd0;
      x_position_b  <= 9'd0;
      y_position_b  <= 8'd0;
    end else begin
      state         <= state_nxt;
      hit_cnt       <= hit_cnt_nxt;
      frm_cnt       <= frm_cnt_nxt;
      start         <= (state_nxt == S_ARM);
      soldier_clear <= (state_nxt == S_CLEAR);
      if ((state_nxt == S_CLEAR) && (rescue_count != 8'hFF))
        rescue_count <= rescue_count + 8'd1;
      if (timeout_hit) timeout_err <= 1'b1;
      if (load_box) begin
        x_position_a <= min_x;
        y_position_a <= min_y;
        x_position_b <= box_xb;
        y_position_b <= box_yb;
      end
    end
  end

  assign busy = (state == S_ARM) || (state == S_SHOW) || (state == S_CLEAR);

endmodule

// File: tb/tb_rescue_detect.sv
// Directed bench for rescue_detect: overlap/box vector table plus
// hand-written sequences for arming, done masking, timeout and reset.
module tb_rescue_detect;

  logic       clk = 1'b0;
  logic       reset_n, frame_tick, enable, soldier_valid, saved_done;
  logic [8:0] player_x, soldier_x;
  logic [7:0] player_y, soldier_y;
  logic       start, soldier_clear, busy, timeout_err;
  logic [8:0] x_position_a, x_position_b;
  logic [7:0] y_position_a, y_position_b;
  logic [7:0] rescue_count;

  int n_pass = 0;
  int n_total = 0;

  rescue_detect dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .enable(enable),
    .player_x(player_x), .player_y(player_y),
    .soldier_x(soldier_x), .soldier_y(soldier_y),
    .soldier_valid(soldier_valid), .saved_done(saved_done),
    .start(start), .x_position_a(x_position_a), .y_position_a(y_position_a),
    .x_position_b(x_position_b), .y_position_b(y_position_b),
    .soldier_clear(soldier_clear), .rescue_count(rescue_count),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] px; logic [7:0] py;
    logic [8:0] sx; logic [7:0] sy;
    logic       hit;
    logic [8:0] xa; logic [7:0] ya;
    logic [8:0] xb; logic [7:0] yb;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic set_pos(input int px, input int py, input int sx, input int sy);
    player_x = 9'(px); player_y = 8'(py);
    soldier_x = 9'(sx); soldier_y = 8'(sy);
  endtask

  // From IDLE with an overlapping pair: two overlap ticks, then ARM.
  task automatic do_arm();
    set_pos(100, 50, 105, 55);
    enable = 1'b1; soldier_valid = 1'b1;
    step();
    tick_step();
    tick_step();
    step();
  endtask

  // From ARM: enter SHOW, let one frame pass, deliver done; ends in IDLE.
  task automatic do_rescue_done();
    tick_step();
    tick_step();
    saved_done = 1'b1;
    step();
    saved_done = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{9'd100, 8'd50,  9'd105, 8'd55,  1'b1, 9'd100, 8'd50,  9'd114, 8'd64};
    vecs[1] = '{9'd315, 8'd235, 9'd312, 8'd232, 1'b1, 9'd312, 8'd232, 9'd319, 8'd239};
    vecs[2] = '{9'd50,  8'd60,  9'd41,  8'd51,  1'b1, 9'd41,  8'd51,  9'd59,  8'd69};
    vecs[3] = '{9'd100, 8'd50,  9'd110, 8'd50,  1'b0, 9'd0, 8'd0, 9'd0, 8'd0};
    vecs[4] = '{9'd110, 8'd50,  9'd100, 8'd59,  1'b0, 9'd0, 8'd0, 9'd0, 8'd0};
    vecs[5] = '{9'd0,   8'd0,   9'd505, 8'd0,   1'b0, 9'd0, 8'd0, 9'd0, 8'd0};
    vecs[6] = '{9'd0,   8'd0,   9'd0,   8'd250, 1'b0, 9'd0, 8'd0, 9'd0, 8'd0};

    reset_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; soldier_valid = 1'b0;
    saved_done = 1'b0;
    set_pos(0, 0, 0, 0);
    step(); step();

    check("rst_start", int'(start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clear", int'(soldier_clear), 0);
    check("rst_count", int'(rescue_count), 0);
    check("rst_terr", int'(timeout_err), 0);
    check("rst_xb", int'(x_position_b), 0);

    // Overlap / box table: two ticks, then one cycle for the ARM transition.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      set_pos(int'(vecs[i].px), int'(vecs[i].py), int'(vecs[i].sx), int'(vecs[i].sy));
      enable = 1'b1; soldier_valid = 1'b1;
      step();
      tick_step();
      tick_step();
      step();
      check($sformatf("v%0d_start", i), int'(start), int'(vecs[i].hit));
      check($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].hit));
      if (vecs[i].hit) begin
        check($sformatf("v%0d_xa", i), int'(x_position_a), int'(vecs[i].xa));
        check($sformatf("v%0d_ya", i), int'(y_position_a), int'(vecs[i].ya));
        check($sformatf("v%0d_xb", i), int'(x_position_b), int'(vecs[i].xb));
        check($sformatf("v%0d_yb", i), int'(y_position_b), int'(vecs[i].yb));
      end
    end

    // Broken overlap run restarts the count.
    do_reset();
    set_pos(100, 50, 105, 55);
    enable = 1'b1; soldier_valid = 1'b1;
    step();
    tick_step();
    set_pos(100, 50, 200, 55);
    tick_step();
    set_pos(100, 50, 105, 55);
    tick_step();
    step();
    check("gap_no_arm", int'(start), 0);
    tick_step();
    step();
    check("gap_arm_t4", int'(start), 1);

    // Tick coinciding with TRACK->ARM must not release ARM.
    do_reset();
    set_pos(100, 50, 105, 55);
    step();
    tick_step();
    tick_step();
    tick_step();
    check("coin_arm", int'(start), 1);
    step();
    check("coin_hold", int'(start), 1);
    tick_step();
    check("coin_show_start", int'(start), 0);
    check("coin_show_busy", int'(busy), 1);

    // Stale done masked until first SHOW tick.
    do_reset();
    do_arm();
    saved_done = 1'b1;
    tick_step();
    step(); step();
    check("stale_busy", int'(busy), 1);
    check("stale_clear", int'(soldier_clear), 0);
    tick_step();
    check("stale_tick_clear", int'(soldier_clear), 0);
    step();
    check("done_clear", int'(soldier_clear), 1);
    check("done_count", int'(rescue_count), 1);
    check("done_box_xa", int'(x_position_a), 100);
    check("done_box_yb", int'(y_position_b), 64);
    saved_done = 1'b0;
    step();
    check("done_pulse_end", int'(soldier_clear), 0);
    check("done_idle", int'(busy), 0);

    // Timeout with enable/valid dropped during ARM/SHOW.
    do_arm();
    enable = 1'b0; soldier_valid = 1'b0;
    tick_step();
    for (int i = 0; i < 39; i++) begin
      tick_step();
      step();
    end
    check("to_busy39", int'(busy), 1);
    check("to_terr39", int'(timeout_err), 0);
    check("to_clear39", int'(soldier_clear), 0);
    tick_step();
    check("to_clear40", int'(soldier_clear), 1);
    check("to_terr40", int'(timeout_err), 1);
    check("to_count", int'(rescue_count), 2);
    step();
    check("to_idle", int'(busy), 0);

    // Drive the count to saturation.
    for (int i = 0; i < 253; i++) begin
      do_arm();
      do_rescue_done();
    end
    check("sat_255", int'(rescue_count), 255);
    do_arm();
    tick_step();
    tick_step();
    saved_done = 1'b1;
    step();
    saved_done = 1'b0;
    check("sat_clear", int'(soldier_clear), 1);
    check("sat_hold", int'(rescue_count), 255);
    step();

    // Reset mid-SHOW with done pending.
    do_arm();
    tick_step();
    tick_step();
    saved_done = 1'b1;
    reset_n = 1'b0;
    step();
    check("mid_clear", int'(soldier_clear), 0);
    check("mid_count", int'(rescue_count), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_start", int'(start), 0);
    check("mid_terr", int'(timeout_err), 0);
    check("mid_xa", int'(x_position_a), 0);
    check("mid_yb", int'(y_position_b), 0);
    reset_n = 1'b1;
    step();
    check("mid_post_clear", int'(soldier_clear), 0);
    check("mid_post_count", int'(rescue_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
